// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with the icache and drives the IF/ID register.
// Optional `FETCH_SKID_EN` adds a one-entry skid so a word returned during a decode stall is kept.
module fetch_stage #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        halt_i,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP_WORD, npc: 32'h0, valid: 1'b0};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_SKID_EN
  ifid_t skid_q, skid_d;
`endif

  // Both outputs come straight from registers: no input-to-output path.
  assign imemaddr = pc_q;
  assign imemREN  = (state_q == FETCH);
  assign instr_o  = ifid_q.instr;
  assign npc_o    = ifid_q.npc;
  assign valid_o  = ifid_q.valid;

  always_comb begin
    // NOTE: every next-state variable gets a hold default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
`ifdef FETCH_SKID_EN
    skid_d  = skid_q;
`endif

    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (halt_i) begin
      state_d = HALTED;
      ifid_d  = BUBBLE;
`ifdef FETCH_SKID_EN
      skid_d  = BUBBLE;
`endif
    end else if (redirect_i) begin
      // The stalled/fetched instruction is younger than the branch, so it is flushed.
      state_d = FETCH;
      pc_d    = {redirect_addr_i[31:2], 2'b00};
      ifid_d  = BUBBLE;
`ifdef FETCH_SKID_EN
      skid_d  = BUBBLE;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          if (!stall_i) begin
            if (ihit) begin
              ifid_d = '{instr: imemload, npc: pc_plus4, valid: 1'b1};
              pc_d   = pc_plus4;
            end else begin
              ifid_d = BUBBLE;
            end
          end
`ifdef FETCH_SKID_EN
          else if (ihit) begin
            skid_d  = '{instr: imemload, npc: pc_plus4, valid: 1'b1};
            pc_d    = pc_plus4;
            state_d = HOLD;
          end
`endif
        end
        HOLD: begin
`ifdef FETCH_SKID_EN
          if (!stall_i) begin
            ifid_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = FETCH;
          end
`else
          state_d = FETCH;
`endif
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      ifid_q  <= BUBBLE;
`ifdef FETCH_SKID_EN
      skid_q  <= BUBBLE;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
`ifdef FETCH_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; expectations are hand-computed per step.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        halt_i;
  logic [31:0] instr_o;
  logic [31:0] npc_o;
  logic        valid_o;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage dut (
    .CLK             (CLK),
    .RST             (RST),
    .ihit            (ihit),
    .imemload        (imemload),
    .imemREN         (imemREN),
    .imemaddr        (imemaddr),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .halt_i          (halt_i),
    .instr_o         (instr_o),
    .npc_o           (npc_o),
    .valid_o         (valid_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                            input logic vld);
    check({tag, ".instr"}, instr_o, ins);
    check({tag, ".npc"}, npc_o, npc);
    check({tag, ".valid"}, {31'b0, valid_o}, {31'b0, vld});
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = 32'h0; stall_i = 1'b0;
    redirect_i = 1'b0; redirect_addr_i = 32'h0; halt_i = 1'b0;
    tick();
    check("rst.addr", imemaddr, 32'h0);
    check("rst.ren", {31'b0, imemREN}, 32'd1);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    RST = 1'b0;

    // Back-to-back hits.
    ihit = 1'b1; imemload = 32'h2001_0005;
    tick();
    check("seq1.addr", imemaddr, 32'h4);
    check_ifid("seq1", 32'h2001_0005, 32'h4, 1'b1);
    tick();
    check("seq2.addr", imemaddr, 32'h8);
    check_ifid("seq2", 32'h2001_0005, 32'h8, 1'b1);

    // Misses: PC holds, bubbles issued.
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("miss.addr", imemaddr, 32'h8);
      check("miss.ren", {31'b0, imemREN}, 32'd1);
      check("miss.valid", {31'b0, valid_o}, 32'd0);
    end

    // Redirect beats stall and a same-cycle hit; low bits are cleared.
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_0103; ihit = 1'b1; stall_i = 1'b1;
    imemload = 32'hDEAD_BEEF;
    tick();
    check("redir.addr", imemaddr, 32'h100);
    check_ifid("redir", 32'h0, 32'h0, 1'b0);
    redirect_i = 1'b0; stall_i = 1'b0; ihit = 1'b0;
    tick();
    check_ifid("redir_gap", 32'h0, 32'h0, 1'b0);
    ihit = 1'b1; imemload = 32'h1111_1111;
    tick();
    check("tgt.addr", imemaddr, 32'h104);
    check_ifid("tgt", 32'h1111_1111, 32'h104, 1'b1);

    // Two-cycle stall with hits present.
    stall_i = 1'b1; imemload = 32'h2222_2222;
    tick();
    check_ifid("stall1", 32'h1111_1111, 32'h104, 1'b1);
`ifdef FETCH_SKID_EN
    check("stall1.addr", imemaddr, 32'h108);
    check("stall1.ren", {31'b0, imemREN}, 32'd0);
`else
    check("stall1.addr", imemaddr, 32'h104);
    check("stall1.ren", {31'b0, imemREN}, 32'd1);
`endif
    imemload = 32'h3333_3333;
    tick();
    check_ifid("stall2", 32'h1111_1111, 32'h104, 1'b1);
`ifdef FETCH_SKID_EN
    check("stall2.addr", imemaddr, 32'h108);
    check("stall2.ren", {31'b0, imemREN}, 32'd0);
`else
    check("stall2.addr", imemaddr, 32'h104);
    check("stall2.ren", {31'b0, imemREN}, 32'd1);
`endif
    // Release: skid drains, or the word at 0x104 is re-read.
    stall_i = 1'b0; imemload = 32'h2222_2222;
    tick();
    check("rel.addr", imemaddr, 32'h108);
    check("rel.ren", {31'b0, imemREN}, 32'd1);
    check_ifid("rel", 32'h2222_2222, 32'h108, 1'b1);

    // Halt beats redirect; only reset leaves HALTED.
    halt_i = 1'b1; redirect_i = 1'b1; redirect_addr_i = 32'h200; imemload = 32'h4444_4444;
    tick();
    check("halt.addr", imemaddr, 32'h108);
    check("halt.ren", {31'b0, imemREN}, 32'd0);
    check_ifid("halt", 32'h0, 32'h0, 1'b0);
    halt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halted.addr", imemaddr, 32'h108);
      check("halted.ren", {31'b0, imemREN}, 32'd0);
      check("halted.valid", {31'b0, valid_o}, 32'd0);
    end
    RST = 1'b1; halt_i = 1'b1;
    tick();
    check("rst2.addr", imemaddr, 32'h0);
    check("rst2.ren", {31'b0, imemREN}, 32'd1);
    check_ifid("rst2", 32'h0, 32'h0, 1'b0);
    RST = 1'b0; halt_i = 1'b0;

    // PC wrap at the top of the address space.
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC; ihit = 1'b0;
    tick();
    check("wrap0.addr", imemaddr, 32'hFFFF_FFFC);
    redirect_i = 1'b0; ihit = 1'b1; imemload = 32'h5555_5555;
    tick();
    check("wrap1.addr", imemaddr, 32'h0);
    check_ifid("wrap1", 32'h5555_5555, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined datapath. It owns the PC and issues instruction reads to the icache, handling the `ihit` handshake. It latches the fetched word and PC+4 into the IF/ID register that feeds the decode stage. Branch/jump redirects and halts come back from later stages; decode-hazard stalls are honoured.

## Interface
Parameters:
- `PC_INIT`: default 32'h0000_0000. PC value loaded on reset.
- `NOP_WORD`: default 32'h0000_0000. Instruction word driven on `instr_o` for a bubble.

Ports:
- `CLK`  in  1  clock, all state on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `ihit`  in  1  icache has returned `imemload` for `imemaddr` this cycle
- `imemload`  in  32  instruction word from icache
- `imemREN`  out  1  instruction read request
- `imemaddr`  out  32  instruction address (= PC)
- `stall_i`  in  1  decode hazard: hold IF/ID contents
- `redirect_i`  in  1  taken branch / jump / jr resolved downstream
- `redirect_addr_i`  in  32  redirect target
- `halt_i`  in  1  halt instruction reached the resolving stage
- `instr_o`  out  32  IF/ID instruction
- `npc_o`  out  32  IF/ID PC+4 of `instr_o`
- `valid_o`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Registered state:
  - `pc`
  - FSM state: FETCH, HOLD, HALTED
  - IF/ID register: `instr_o`, `npc_o`, `valid_o`
  - skid entry: word, npc, valid; present only with the macro
- Outputs:
  - `imemaddr = pc`.
  - `imemREN = 1` in FETCH, otherwise 0.
- Priority each cycle, highest first: `RST` > `halt_i` > `redirect_i` > `stall_i` > `ihit`.
- `halt_i`:
  - next state HALTED; IF/ID loaded with a bubble (`instr_o=NOP_WORD`, `npc_o=0`, `valid_o=0`); `pc` frozen; skid cleared.
  - HALTED exits only on `RST`.
- `redirect_i` (not halted):
  - `pc <= {redirect_addr_i[31:2],2'b00}`; IF/ID loaded with a bubble; skid cleared; next state FETCH.
  - A same-cycle `ihit` is discarded.
  - Redirect overrides `stall_i`, because the stalled instruction is younger than the branch and is being flushed.
- FETCH, `stall_i=0`:
  - `ihit=1`: IF/ID <= {`imemload`, `pc+4`, 1}; `pc <= pc+4`.
  - `ihit=0`: IF/ID <= bubble; `pc` unchanged.
- FETCH, `stall_i=1`: IF/ID holds its value. Fetch behaviour depends on `FETCH_SKID_EN` (see Configuration).
- HOLD: `imemREN=0`. When `stall_i` falls, IF/ID <= skid, skid cleared, next state FETCH.
- PC arithmetic: 32-bit modulo, so 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.

## Timing
- After the first `RST` edge:
  - `pc=PC_INIT`, state FETCH, so `imemREN=1` and `imemaddr=PC_INIT`.
  - `instr_o=NOP_WORD`, `npc_o=0`, `valid_o=0`, skid invalid.
- `RST` asserted mid-operation overrides everything on that edge, including `halt_i`, `redirect_i` and `ihit`.
- `ihit` in cycle n produces `instr_o`/`valid_o` in cycle n+1. Back-to-back `ihit` gives one instruction per cycle.
- A redirect in cycle n puts the target on `imemaddr` in cycle n+1. The earliest target instruction appears on `instr_o` in cycle n+2.
- `imemaddr` and `imemREN` depend only on registered state; there is no combinational input-to-output path.
- `imemaddr` changes only on a rising edge, and is stable while a request is outstanding without `ihit`.

## Configuration
- `FETCH_SKID_EN` defined:
  - In FETCH with `stall_i=1` and `ihit=1`, the word is captured into the skid as {`imemload`, `pc+4`}; `pc <= pc+4`; next state HOLD.
  - The stall-release cycle therefore needs no refetch.
- `FETCH_SKID_EN` not defined:
  - In FETCH with `stall_i=1`, `ihit` is ignored, `pc` is unchanged and `imemREN` stays 1, so the same address is re-read after the stall.
  - HOLD is unreachable and the skid registers are not synthesized.

## Test plan
- Reset, then `ihit=1` continuously with `imemload=32'h2001_0005` → `imemaddr` steps 0, 4, 8; `instr_o=32'h2001_0005`, `npc_o=4` one cycle after the first `ihit`; `valid_o=1`.
- `ihit=0` for 3 cycles at `pc=8` → `imemaddr` holds 8; `valid_o=0` for 3 cycles; no PC advance.
- `redirect_i=1`, `redirect_addr_i=32'h0000_0103`, with `ihit=1` and `stall_i=1` in the same cycle → next cycle `imemaddr=32'h100`, `valid_o=0`; the discarded word never appears on `instr_o`.
- `stall_i=1` for 2 cycles with `ihit=1`:
  - With `FETCH_SKID_EN`: IF/ID holds; `imemREN=0` in the second cycle; the skid word appears the cycle after release.
  - Without it: `imemaddr` stays constant across the stall.
- `halt_i=1` together with `redirect_i=1` → HALTED; `imemREN=0` and `valid_o=0` indefinitely; `pc` unchanged; a later `RST` restores `imemaddr=PC_INIT` and `imemREN=1`.
- `redirect_addr_i=32'hFFFF_FFFC`, then one `ihit` → `imemaddr=32'h0000_0000`, `npc_o=32'h0000_0000`.
